// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_t;
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX feeds a source register of the instruction in decode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the hazard flag itself is what stalls the front end.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rt,
   input  logic [REG_IDX_W-1:0] ex_rt,
   input  logic                 ex_mem_read,
   output logic                 lu
);

   // r0 is hardwired zero, so a load into it never creates a dependency.
   assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: IF/ID and ID/EX enables for load-use, taken branch and MULT/DIV (PIPELINE_HAZARD_MULDIV_EN).
// Latency: controls are combinational from state and inputs; stall_cycles lags by one cycle.
// Backpressure: front end held (pc/ifid write low) for load-use and the full MULT/DIV occupancy.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULDIV_LAT = 32,
   parameter int CNT_W      = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rt,
   input  logic [REG_IDX_W-1:0] ex_rt,
   input  logic                 ex_mem_read,
   input  logic                 ex_branch_taken,
   input  logic                 ex_muldiv_start,
   output logic                 pc_write,
   output logic                 ifid_write,
   output logic                 ifid_flush,
   output logic                 idex_write,
   output logic                 idex_bubble,
   output logic                 busy,
   output logic [CNT_W-1:0]     stall_cycles
);

   logic             lu;
   logic             md_busy;
   logic             md_go;
   logic [CNT_W-1:0] stall_q;

   load_use_detect u_lu (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_rt       (ex_rt),
      .ex_mem_read (ex_mem_read),
      .lu          (lu)
   );

`ifdef PIPELINE_HAZARD_MULDIV_EN
   localparam logic [7:0] MD_INIT = 8'(MULDIV_LAT - 1);

   hz_state_t  state;
   logic [7:0] md_cnt;

   // The start cycle counts as the first stall cycle, so MD_BUSY lasts MULDIV_LAT-1 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!ex_branch_taken && ex_muldiv_start) begin
                  state  <= MD_BUSY;
                  md_cnt <= MD_INIT;
               end
            end
            MD_BUSY: begin
               md_cnt <= md_cnt - 8'd1;
               if (md_cnt == 8'd1) begin
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign md_busy = (state == MD_BUSY);
   assign md_go   = (state == RUN) && ex_muldiv_start;
`else
   logic unused_md;

   assign unused_md = ^{ex_muldiv_start, MULDIV_LAT[7:0]};
   assign md_busy   = 1'b0;
   assign md_go     = 1'b0;
`endif

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_bubble = 1'b0;
      if (rst) begin
         // Flush both pipeline registers to NOPs while reset is held.
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (md_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_write = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (md_go) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_write = 1'b0;
      end else if (lu) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   assign busy = md_busy && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles = rst ? '0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: a driver applies directed vectors and queues hand-computed outputs; a monitor compares each cycle.
module tb_pipeline_hazard_ctrl;

   localparam int LAT = 4;
   localparam int CW  = 4;

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, busy}
   localparam logic [5:0] C_RST = 6'b001110;
   localparam logic [5:0] C_NONE = 6'b110100;
   localparam logic [5:0] C_LU  = 6'b000110;
   localparam logic [5:0] C_BR  = 6'b111110;
   localparam logic [5:0] C_MS  = 6'b000000;
   localparam logic [5:0] C_MB  = 6'b000001;

   typedef struct packed {
      logic [5:0]    ctl;
      logic [CW-1:0] stall;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    id_rs = '0;
   logic [4:0]    id_rt = '0;
   logic          id_uses_rt = 1'b0;
   logic [4:0]    ex_rt = '0;
   logic          ex_mem_read = 1'b0;
   logic          ex_branch_taken = 1'b0;
   logic          ex_muldiv_start = 1'b0;
   logic          pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, busy;
   logic [CW-1:0] stall_cycles;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   midx   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .ex_rt           (ex_rt),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .ex_muldiv_start (ex_muldiv_start),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .idex_write      (idex_write),
      .idex_bubble     (idex_bubble),
      .busy            (busy),
      .stall_cycles    (stall_cycles)
   );

   task automatic vec(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] ert, input logic mr,
                      input logic br, input logic ms, input logic [5:0] ctl,
                      input logic [CW-1:0] st);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r;
      id_rs           = rs;
      id_rt           = rt;
      id_uses_rt      = urt;
      ex_rt           = ert;
      ex_mem_read     = mr;
      ex_branch_taken = br;
      ex_muldiv_start = ms;
      e.ctl   = ctl;
      e.stall = st;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [5:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, busy};
            checks++;
            if (got !== e.ctl) begin
               errors++;
               $display("FAIL ctl vec %0d: got %b expected %b", midx, got, e.ctl);
            end
            checks++;
            if (stall_cycles !== e.stall) begin
               errors++;
               $display("FAIL stall_cycles vec %0d: got %0d expected %0d", midx, stall_cycles, e.stall);
            end
            midx++;
         end
      end
   end

   initial begin : driver
      int budget;
      // reset
      vec(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
      vec(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
      // load r8 then use r8: one stall, then clear
      vec(0, 8, 0, 0, 8, 1, 0, 0, C_LU, 0);
      vec(0, 8, 0, 0, 8, 0, 0, 0, C_NONE, 1);
      // load to r0 never stalls
      vec(0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 1);
      // rt dependency only counts when rt is a source
      vec(0, 3, 9, 1, 9, 1, 0, 0, C_LU, 1);
      vec(0, 3, 9, 0, 9, 1, 0, 0, C_NONE, 2);
      // taken branch beats a coincident load-use
      vec(0, 0, 5, 1, 5, 1, 1, 0, C_BR, 2);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2);
`ifdef PIPELINE_HAZARD_MULDIV_EN
      // 4-cycle muldiv; branch/start ignored while busy
      vec(0, 0, 0, 0, 0, 0, 0, 1, C_MS, 2);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_MB, 3);
      vec(0, 0, 0, 0, 0, 0, 1, 1, C_MB, 4);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_MB, 5);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 6);
      // reset in the 2nd MD_BUSY cycle aborts the operation
      vec(0, 0, 0, 0, 0, 0, 0, 1, C_MS, 6);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_MB, 7);
      vec(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
`else
      // muldiv start has no effect without the feature
      vec(0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2);
      vec(0, 8, 0, 0, 8, 1, 0, 1, C_LU, 2);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 3);
      vec(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);
`endif
      // 20 back-to-back load-use stalls saturate the 4-bit counter
      for (int k = 0; k < 20; k++) begin
         vec(0, 8, 0, 0, 8, 1, 0, 0, C_LU, (k < 15) ? 4'(k) : 4'd15);
      end
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 15);
      vec(0, 8, 0, 0, 8, 1, 0, 0, C_LU, 15);
      vec(0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 15);

      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
